i2s_pcm_tx: RTL



---
 rtl/i2s_pcm_tx.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/i2s_pcm_tx.sv
// i2s_pcm_tx: WS-master I2S transmitter.
// Serialises left/right PCM pairs MSB first with the I2S one-bit delay.
// A one-entry pending register with a valid/ready handshake feeds the
// frame registers at each frame boundary. If no pair is pending, the
// previous frame repeats and underrun pulses.
module i2s_pcm_tx #(
    parameter int NUMBER_OF_BITS = 8,
    parameter int SLOT_CYCLES    = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      ena,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [NUMBER_OF_BITS-1:0] s_left,
    input  logic [NUMBER_OF_BITS-1:0] s_right,
    output logic                      ws,
    output logic                      sd,
    output logic                      frame_start,
    output logic                      underrun
);

    // Minimum width that holds SLOT_CYCLES-1.
    localparam int CW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SLOT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_LSB  = CW'(NUMBER_OF_BITS);
    localparam logic [NUMBER_OF_BITS-1:0] BIT_ONE = NUMBER_OF_BITS'(1);

    // The slot must hold the delay bit, all data bits and at least one idle bit.
    generate
        if (NUMBER_OF_BITS < 1) begin : g_bad_bits
            $error("i2s_pcm_tx: NUMBER_OF_BITS must be at least 1");
        end
        if (SLOT_CYCLES < NUMBER_OF_BITS + 2) begin : g_bad_slot
            $error("i2s_pcm_tx: SLOT_CYCLES must be >= NUMBER_OF_BITS+2");
        end
    endgenerate

    typedef enum logic {
        SLOT_LEFT  = 1'b0,
        SLOT_RIGHT = 1'b1
    } slot_e;

    slot_e                     slot;
    slot_e                     slot_nxt;
    logic [CW-1:0]             cnt;
    logic [CW-1:0]             cnt_nxt;
    logic                      sd_nxt;
    logic                      slot_end;
    logic                      boundary;
    logic                      accept;
    logic                      pending_full;
    logic [NUMBER_OF_BITS-1:0] pend_left;
    logic [NUMBER_OF_BITS-1:0] pend_right;
    logic [NUMBER_OF_BITS-1:0] frame_left;
    logic [NUMBER_OF_BITS-1:0] frame_right;
    logic [NUMBER_OF_BITS-1:0] slot_word;
    logic [NUMBER_OF_BITS-1:0] bit_sel;

    assign ws       = (slot == SLOT_RIGHT);
    assign s_ready  = !pending_full;
    assign accept   = s_valid && !pending_full;
    assign slot_end = ena && (cnt == CNT_LAST);
    assign boundary = slot_end && (slot == SLOT_RIGHT);

    // Slot state register: left/right half of the frame, drives ws.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot <= SLOT_LEFT;
        end else begin
            slot <= slot_nxt;
        end
    end

    // Next slot and next count: advance only while enabled, flip slot on wrap.
    always_comb begin
        slot_nxt = slot;
        cnt_nxt  = cnt;
        if (ena) begin
            if (cnt == CNT_LAST) begin
                cnt_nxt  = '0;
                slot_nxt = (slot == SLOT_LEFT) ? SLOT_RIGHT : SLOT_LEFT;
            end else begin
                cnt_nxt = cnt + CW'(1);
            end
        end
    end

    // Select the bit that will be on the line once cnt takes cnt_nxt.
    // Frame registers only change when cnt_nxt is 0, where sd is 0 anyway,
    // so the pre-edge frame word is always the right source.
    always_comb begin
        slot_word = (slot_nxt == SLOT_RIGHT) ? frame_right : frame_left;
        bit_sel   = '0;
        if ((cnt_nxt != '0) && (cnt_nxt <= CNT_LSB)) begin
            bit_sel = BIT_ONE << (NUMBER_OF_BITS - int'(cnt_nxt));
        end
        sd_nxt = |(slot_word & bit_sel);
    end

    // Slot counter and registered serial data; both hold while ena is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            sd  <= 1'b0;
        end else begin
            cnt <= cnt_nxt;
            sd  <= sd_nxt;
        end
    end

    // Frame boundary strobes: frame_start always, underrun when nothing pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_start <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            frame_start <= boundary;
            underrun    <= boundary && !pending_full;
        end
    end

    // Pending register: boundary drains a full entry, otherwise accept fills it.
    // Accept is only possible while empty, so it can never collide with a drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_full <= 1'b0;
            pend_left    <= '0;
            pend_right   <= '0;
        end else if (boundary && pending_full) begin
            pending_full <= 1'b0;
        end else if (accept) begin
            pending_full <= 1'b1;
            pend_left    <= s_left;
            pend_right   <= s_right;
        end
    end

    // Frame registers: reload from pending at a boundary, else hold (repeat).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_left  <= '0;
            frame_right <= '0;
        end else if (boundary && pending_full) begin
            frame_left  <= pend_left;
            frame_right <= pend_right;
        end
    end

endmodule
